qspi_flash_responder: RTL and testbench



---
 rtl/qspi_flash_responder.sv | 272 +++++++++++++++++++++++++++
 tb/tb_qspi_flash_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/qspi_flash_responder.sv
// -----------------------------------------------------------------------------
// qspi_flash_responder
// Flash end of the quad-I/O XIP read link. Decodes the quad fast-read command
// (CMD_QREAD), collects a 24-bit address and mode byte, waits DUMMY_CYCLES sck
// rises, then streams bytes fetched from a synchronous byte-wide memory back
// over SIO[3:0], high nibble first, one nibble per falling sck edge.
//
// Optional build macro: QSPI_RESP_CONT_READ_EN
//   Defined   : mode byte with [5:4] == 2'b10 arms continuous read; the next
//               transaction starts at the address phase (no command phase).
//   Undefined : mode byte is captured and ignored; every transaction starts
//               with a command phase.
//
// Ports
//   HCLK       in   system clock (sck is a synchronous, HCLK-registered input)
//   HRESETn    in   asynchronous active-low reset
//   sck        in   serial clock from the controller
//   ce_n       in   chip enable, active low
//   din[3:0]   in   SIO lines as driven by the controller
//   dout[3:0]  out  SIO data driven by the responder
//   douten[3:0]out  per-line output enable (all on or all off)
//   mem_addr   out  byte address to backing memory
//   mem_rd     out  single-cycle read strobe
//   mem_rdata  in   read data, valid the cycle after mem_rd
// -----------------------------------------------------------------------------
module qspi_flash_responder #(
   parameter int unsigned DUMMY_CYCLES = 4,
   parameter logic [7:0]  CMD_QREAD    = 8'hEB
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        sck,
   input  logic        ce_n,
   input  logic [3:0]  din,
   output logic [3:0]  dout,
   output logic [3:0]  douten,
   output logic [23:0] mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_rdata
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned ADDR_W = 24;

   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CMD_LAST   = CNT_W'(7);
   localparam logic [CNT_W-1:0]  ADDR_LAST  = CNT_W'(5);
   localparam logic [CNT_W-1:0]  MODE_LAST  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  DUMMY_LAST = CNT_W'(DUMMY_CYCLES - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_CMD, ST_ADDR, ST_MODE, ST_DUMMY, ST_DATA, ST_IGNORE
   } state_t;

   state_t            r_state, w_state_nxt, w_phase, w_start_state;

   logic              r_sck_q;
   logic              w_rise, w_fall;

   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [6:0]        r_cmd, w_cmd_nxt;
   logic [7:0]        w_cmd_byte;
   logic [ADDR_W-1:0] r_addr, w_addr_nxt;
   logic [7:0]        r_mode, w_mode_nxt;
   logic [7:0]        w_mode_byte;
   logic [7:0]        r_buf, w_buf_nxt, w_buf_src;
   logic [7:0]        r_pref, w_pref_nxt, w_pref_src;
   logic              r_lo_next, w_lo_next_nxt;
   logic              r_dummy_done, w_dummy_done_nxt;
   logic              r_rd_pref, w_rd_pref_nxt;
   logic              r_rd_d1, r_rd_pref_d1;

   logic [3:0]        r_dout, w_dout_nxt;
   logic [3:0]        r_douten, w_douten_nxt;
   logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
   logic              r_mem_rd, w_mem_rd_nxt;

   // Upper mode bits are only meaningful with continuous read enabled.
   logic              w_unused;
   assign w_unused = ^r_mode;

`ifdef QSPI_RESP_CONT_READ_EN
   logic              r_cont, w_cont_nxt;
   assign w_start_state = r_cont ? ST_ADDR : ST_CMD;
`else
   assign w_start_state = ST_CMD;
`endif

   assign w_rise      = sck & ~r_sck_q;
   assign w_fall      = ~sck & r_sck_q;
   assign w_cmd_byte  = {r_cmd, din[0]};
   assign w_mode_byte = {r_mode[3:0], din};

   // Read data lands the cycle after the strobe; forward it when it is needed
   // in the same cycle it is being captured.
   assign w_buf_src  = (r_rd_d1 && !r_rd_pref_d1) ? mem_rdata : r_buf;
   assign w_pref_src = (r_rd_d1 &&  r_rd_pref_d1) ? mem_rdata : r_pref;

   // Phase this cycle's sck edge belongs to; IDLE folds into the first phase
   // so a rise coincident with ce_n falling is taken as the first bit.
   always_comb begin
      w_phase = r_state;
      if (r_state == ST_IDLE && !ce_n) w_phase = w_start_state;
   end

   // State register
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) r_state <= ST_IGNORE;   // wait for ce_n high before any transaction
      else          r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = w_phase;
      if (ce_n) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (w_phase)
            ST_CMD:   if (w_rise && r_cnt == CMD_LAST)
                         w_state_nxt = (w_cmd_byte == CMD_QREAD) ? ST_ADDR : ST_IGNORE;
            ST_ADDR:  if (w_rise && r_cnt == ADDR_LAST) w_state_nxt = ST_MODE;
            ST_MODE:  if (w_rise && r_cnt == MODE_LAST) w_state_nxt = ST_DUMMY;
            ST_DUMMY: if (w_fall && r_dummy_done)        w_state_nxt = ST_DATA;
            default:  ;
         endcase
      end
   end

   // Output / datapath next values
   always_comb begin
      w_cnt_nxt        = r_cnt;
      w_cmd_nxt        = r_cmd;
      w_addr_nxt       = r_addr;
      w_mode_nxt       = r_mode;
      w_buf_nxt        = r_buf;
      w_pref_nxt       = r_pref;
      w_lo_next_nxt    = r_lo_next;
      w_dummy_done_nxt = r_dummy_done;
      w_dout_nxt       = r_dout;
      w_douten_nxt     = r_douten;
      w_mem_addr_nxt   = r_mem_addr;
      w_mem_rd_nxt     = 1'b0;
      w_rd_pref_nxt    = 1'b0;
`ifdef QSPI_RESP_CONT_READ_EN
      w_cont_nxt       = r_cont;
`endif

      // Capture returning read data into buffer or prefetch register.
      if (r_rd_d1) begin
         if (r_rd_pref_d1) w_pref_nxt = mem_rdata;
         else              w_buf_nxt  = mem_rdata;
      end

      if (ce_n) begin
         w_cnt_nxt        = '0;
         w_douten_nxt     = 4'h0;
         w_lo_next_nxt    = 1'b0;
         w_dummy_done_nxt = 1'b0;
      end else begin
         case (w_phase)
            ST_CMD: if (w_rise) begin
               w_cmd_nxt = w_cmd_byte[6:0];
               w_cnt_nxt = (r_cnt == CMD_LAST) ? '0 : r_cnt + CNT_ONE;
            end
            ST_ADDR: if (w_rise) begin
               w_addr_nxt = {r_addr[ADDR_W-5:0], din};
               w_cnt_nxt  = (r_cnt == ADDR_LAST) ? '0 : r_cnt + CNT_ONE;
            end
            ST_MODE: if (w_rise) begin
               w_mode_nxt = w_mode_byte;
               if (r_cnt == MODE_LAST) begin
                  w_cnt_nxt      = '0;
                  w_mem_addr_nxt = r_addr;
                  w_mem_rd_nxt   = 1'b1;
`ifdef QSPI_RESP_CONT_READ_EN
                  w_cont_nxt     = (w_mode_byte[5:4] == 2'b10);
`endif
               end else begin
                  w_cnt_nxt = r_cnt + CNT_ONE;
               end
            end
            ST_DUMMY: begin
               if (w_rise && !r_dummy_done) begin
                  if (r_cnt == DUMMY_LAST) w_dummy_done_nxt = 1'b1;
                  else                     w_cnt_nxt        = r_cnt + CNT_ONE;
               end
               // First data nibble: high half of the first byte, prefetch next.
               if (w_fall && r_dummy_done) begin
                  w_buf_nxt        = w_buf_src;
                  w_dout_nxt       = w_buf_src[7:4];
                  w_douten_nxt     = 4'hF;
                  w_lo_next_nxt    = 1'b1;
                  w_dummy_done_nxt = 1'b0;
                  w_cnt_nxt        = '0;
                  w_mem_addr_nxt   = r_mem_addr + ADDR_ONE;
                  w_mem_rd_nxt     = 1'b1;
                  w_rd_pref_nxt    = 1'b1;
               end
            end
            ST_DATA: if (w_fall) begin
               if (r_lo_next) begin
                  w_dout_nxt    = r_buf[3:0];
                  w_lo_next_nxt = 1'b0;
               end else begin
                  w_buf_nxt      = w_pref_src;
                  w_dout_nxt     = w_pref_src[7:4];
                  w_lo_next_nxt  = 1'b1;
                  w_mem_addr_nxt = r_mem_addr + ADDR_ONE;
                  w_mem_rd_nxt   = 1'b1;
                  w_rd_pref_nxt  = 1'b1;
               end
            end
            ST_IGNORE: w_douten_nxt = 4'h0;
            default:   ;
         endcase
      end
   end

   // Datapath and output registers
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_sck_q      <= 1'b0;
         r_cnt        <= '0;
         r_cmd        <= '0;
         r_addr       <= '0;
         r_mode       <= '0;
         r_buf        <= '0;
         r_pref       <= '0;
         r_lo_next    <= 1'b0;
         r_dummy_done <= 1'b0;
         r_rd_pref    <= 1'b0;
         r_rd_d1      <= 1'b0;
         r_rd_pref_d1 <= 1'b0;
         r_dout       <= 4'h0;
         r_douten     <= 4'h0;
         r_mem_addr   <= '0;
         r_mem_rd     <= 1'b0;
      end else begin
         r_sck_q      <= sck;
         r_cnt        <= w_cnt_nxt;
         r_cmd        <= w_cmd_nxt;
         r_addr       <= w_addr_nxt;
         r_mode       <= w_mode_nxt;
         r_buf        <= w_buf_nxt;
         r_pref       <= w_pref_nxt;
         r_lo_next    <= w_lo_next_nxt;
         r_dummy_done <= w_dummy_done_nxt;
         r_rd_pref    <= w_rd_pref_nxt;
         r_rd_d1      <= r_mem_rd;
         r_rd_pref_d1 <= r_rd_pref;
         r_dout       <= w_dout_nxt;
         r_douten     <= w_douten_nxt;
         r_mem_addr   <= w_mem_addr_nxt;
         r_mem_rd     <= w_mem_rd_nxt;
      end
   end

`ifdef QSPI_RESP_CONT_READ_EN
   // Continuous-read arm flag
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) r_cont <= 1'b0;
      else          r_cont <= w_cont_nxt;
   end
`endif

   assign dout     = r_dout;
   assign douten   = r_douten;
   assign mem_addr = r_mem_addr;
   assign mem_rd   = r_mem_rd;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// -----------------------------------------------------------------------------
// tb_qspi_flash_responder
// Directed bench for qspi_flash_responder. Acts as the QSPI controller and as
// the backing memory. Expected data nibbles and expected memory read addresses
// are queued when a transaction is issued and popped when the responder
// drives a nibble or strobes mem_rd.
// -----------------------------------------------------------------------------
module tb_qspi_flash_responder;

   localparam int unsigned DUMMY = 4;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        sck;
   logic        ce_n;
   logic [3:0]  din;
   logic [3:0]  dout;
   logic [3:0]  douten;
   logic [23:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_rdata = 8'h00;

   int checks = 0;
   int errors = 0;

   logic [3:0]  exp_nib_q[$];
   logic [23:0] exp_rd_q[$];
   logic [3:0]  last_nib = 4'h0;
   logic        prev_rd  = 1'b0;

   always #5 HCLK = ~HCLK;

   qspi_flash_responder #(.DUMMY_CYCLES(DUMMY), .CMD_QREAD(8'hEB)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .sck       (sck),
      .ce_n      (ce_n),
      .din       (din),
      .dout      (dout),
      .douten    (douten),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .mem_rdata (mem_rdata)
   );

   // Backing memory contents
   function automatic logic [7:0] mem_byte(input logic [23:0] a);
      logic [7:0] tbl [8];
      tbl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      if (a == 24'hFFFFFF) return 8'hAB;
      if (a < 24'd8)       return tbl[a[2:0]];
      return 8'h00;
   endfunction

   always @(posedge HCLK) if (mem_rd) mem_rdata <= mem_byte(mem_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Every read strobe must match the next queued address; no back-to-back strobes.
   always @(negedge HCLK) begin
      if (mem_rd) begin
         chk("mem_rd_addr", {8'h00, mem_addr},
             (exp_rd_q.size() != 0) ? {8'h00, exp_rd_q.pop_front()} : 32'hDEAD_BEEF);
         chk("mem_rd_gap", {31'b0, prev_rd}, 32'h0);
      end
      prev_rd <= mem_rd;
   end

   task automatic push_nibs(input logic [31:0] v, input int n);
      for (int k = 0; k < n; k++) exp_nib_q.push_back(v[31-4*k -: 4]);
   endtask

   task automatic push_rds(input logic [23:0] start, input int n);
      for (int k = 0; k < n; k++) exp_rd_q.push_back(24'(start + 24'(k)));
   endtask

   // One sck period: fall, low phase, optional check, rise, high phase.
   task automatic pulse(input logic [3:0] d, input bit data_chk);
      logic [31:0] e;
      sck = 1'b0;
      din = d;
      repeat (3) @(negedge HCLK);
      if (data_chk) begin
         e = (exp_nib_q.size() != 0) ? {24'h0, 4'hF, exp_nib_q.pop_front()} : 32'hDEAD_BEEF;
         chk("data_nibble", {24'h0, douten, dout}, e);
         last_nib = e[3:0];
      end else begin
         chk("douten_off", {28'h0, douten}, 32'h0);
      end
      sck = 1'b1;
      repeat (3) @(negedge HCLK);
   endtask

   task automatic txn(input logic [7:0] cmd, input bit send_cmd, input bit simul,
                      input logic [23:0] addr, input logic [7:0] mode,
                      input int ndata, input bit data_on);
      int first;
      first = 7;
      if (simul) begin
         din  = {3'b000, cmd[7]};
         ce_n = 1'b0;
         sck  = 1'b1;
         repeat (3) @(negedge HCLK);
         first = 6;
      end else begin
         ce_n = 1'b0;
      end
      if (send_cmd) for (int i = first; i >= 0; i--) pulse({3'b000, cmd[i]}, 1'b0);
      for (int i = 5; i >= 0; i--) pulse(addr[i*4 +: 4], 1'b0);
      pulse(mode[7:4], 1'b0);
      pulse(mode[3:0], 1'b0);
      for (int i = 0; i < int'(DUMMY); i++) pulse(4'h0, 1'b0);
      for (int i = 0; i < ndata; i++) pulse(4'h0, data_on);
   endtask

   task automatic end_txn(input bit chk_hold);
      ce_n = 1'b1;
      @(negedge HCLK);
      chk("douten_ce_high", {28'h0, douten}, 32'h0);
      if (chk_hold) chk("dout_hold", {28'h0, dout}, {28'h0, last_nib});
      sck = 1'b0;
      repeat (4) @(negedge HCLK);
   endtask

   initial begin
      HRESETn = 1'b0;
      sck     = 1'b0;
      ce_n    = 1'b1;
      din     = 4'h0;
      repeat (3) @(negedge HCLK);
      chk("rst_dout",     {28'h0, dout},     32'h0);
      chk("rst_douten",   {28'h0, douten},   32'h0);
      chk("rst_mem_addr", {8'h0, mem_addr},  32'h0);
      chk("rst_mem_rd",   {31'h0, mem_rd},   32'h0);
      HRESETn = 1'b1;
      repeat (3) @(negedge HCLK);

      // Read from 0x000000
      push_nibs(32'h11223344, 8); push_rds(24'h000000, 5);
      txn(8'hEB, 1'b1, 1'b0, 24'h000000, 8'h00, 8, 1'b1); end_txn(1'b1);

      // Read from 0x000004
      push_nibs(32'h55667788, 8); push_rds(24'h000004, 5);
      txn(8'hEB, 1'b1, 1'b0, 24'h000004, 8'h00, 8, 1'b1); end_txn(1'b1);

      // Address wrap 0xFFFFFF -> 0x000000
      push_nibs(32'hAB110000, 4); push_rds(24'hFFFFFF, 3);
      txn(8'hEB, 1'b1, 1'b0, 24'hFFFFFF, 8'h00, 4, 1'b1); end_txn(1'b1);

      // Unsupported command: bus stays released, no memory reads
      txn(8'h03, 1'b1, 1'b0, 24'h000000, 8'h00, 4, 1'b0); end_txn(1'b0);

      // ce_n fall with sck rise in the same cycle; first bit counts
      push_nibs(32'h33440000, 4); push_rds(24'h000002, 3);
      txn(8'hEB, 1'b1, 1'b1, 24'h000002, 8'h00, 4, 1'b1); end_txn(1'b1);

      // Reset during DATA
      push_nibs(32'h11200000, 3); push_rds(24'h000000, 3);
      txn(8'hEB, 1'b1, 1'b0, 24'h000000, 8'h00, 3, 1'b1);
      HRESETn = 1'b0;
      #1;
      chk("rst_mid_dout",   {28'h0, dout},   32'h0);
      chk("rst_mid_douten", {28'h0, douten}, 32'h0);
      chk("rst_mid_mem_rd", {31'h0, mem_rd}, 32'h0);
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;
      for (int i = 0; i < 6; i++) pulse(4'hF, 1'b0);
      end_txn(1'b0);

      // Normal operation after reset recovery
      push_nibs(32'h11220000, 4); push_rds(24'h000000, 3);
      txn(8'hEB, 1'b1, 1'b0, 24'h000000, 8'h00, 4, 1'b1); end_txn(1'b1);

`ifdef QSPI_RESP_CONT_READ_EN
      // Arm continuous read, then command-less transaction, then disarm
      push_nibs(32'h11220000, 4); push_rds(24'h000000, 3);
      txn(8'hEB, 1'b1, 1'b0, 24'h000000, 8'hA0, 4, 1'b1); end_txn(1'b1);
      push_nibs(32'h55660000, 4); push_rds(24'h000004, 3);
      txn(8'h00, 1'b0, 1'b0, 24'h000004, 8'h00, 4, 1'b1); end_txn(1'b1);
      push_nibs(32'h11220000, 4); push_rds(24'h000000, 3);
      txn(8'hEB, 1'b1, 1'b0, 24'h000000, 8'h00, 4, 1'b1); end_txn(1'b1);
`else
      // Mode 0xA0 has no lasting effect; next transaction still needs a command
      push_nibs(32'h11220000, 4); push_rds(24'h000000, 3);
      txn(8'hEB, 1'b1, 1'b0, 24'h000000, 8'hA0, 4, 1'b1); end_txn(1'b1);
      push_nibs(32'h55660000, 4); push_rds(24'h000004, 3);
      txn(8'hEB, 1'b1, 1'b0, 24'h000004, 8'h00, 4, 1'b1); end_txn(1'b1);
`endif

      repeat (5) @(negedge HCLK);
      chk("nibble_queue_drained", 32'(exp_nib_q.size()), 32'h0);
      chk("read_queue_drained",   32'(exp_rd_q.size()),  32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
